// File: rtl/async_down_counter.sv
// ---------------------------------------------------------------------------
// async_down_counter
//   Ripple (asynchronous) binary down counter, modulo 2^WIDTH.
//   Stage 0 toggles on the rising edge of clk while en is high. Each higher
//   stage is clocked by the bit below it. A rising edge of the lower bit is
//   a borrow, so the count sequence runs 0 -> all-ones -> ... -> 1 -> 0.
//   Stage outputs double as divided clocks: q[i] = clk / 2^(i+1).
//
// Ports
//   clk : counter clock (stage 0 only)
//   rst : asynchronous, active-low clear of every stage
//   en  : count enable, sampled by stage 0 on the rising edge of clk
//   q   : current count, q[0] is the LSB (glitches while the chain ripples)
//   tc  : terminal count, combinational decode of q == 0
// ---------------------------------------------------------------------------

// Single toggle flip-flop with asynchronous active-low clear.
module async_down_counter_tff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic q_o
);

  logic toggle_q;
  logic toggle_d;

  always_comb begin
    toggle_d = ~toggle_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toggle_q <= 1'b0;
    end else if (en_i) begin
      toggle_q <= toggle_d;
    end
  end

  assign q_o = toggle_q;

endmodule

module async_down_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // Stage 0: the only stage that sees clk and en. Holding it freezes the
  // whole chain, since no higher stage can see a clock edge.
  async_down_counter_tff u_stage0 (
    .clk_i  (clk),
    .rst_ni (rst),
    .en_i   (en),
    .q_o    (q[0])
  );

  // Stages 1..WIDTH-1: clocked by the rising edge of the bit below, which
  // is the borrow out of that bit when counting down.
  for (genvar i = 1; i < WIDTH; i++) begin : g_stage
    async_down_counter_tff u_stage (
      .clk_i  (q[i-1]),
      .rst_ni (rst),
      .en_i   (1'b1),
      .q_o    (q[i])
    );
  end

  assign tc = (q == '0);

endmodule

// File: tb/tb_async_down_counter.sv
module tb_async_down_counter;

  logic       clk;
  logic       rst2, en2;
  logic [1:0] q2;
  logic       tc2;
  logic       rst4, en4;
  logic [3:0] q4;
  logic       tc4;

  int total  = 0;
  int passed = 0;

  async_down_counter #(.WIDTH(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .en  (en2),
    .q   (q2),
    .tc  (tc2)
  );

  async_down_counter #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .en  (en4),
    .q   (q4),
    .tc  (tc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic       en;
    logic [1:0] q;
    logic       tc;
  } vec_t;

  vec_t vecs[14];

  // Divider monitors, active only during the free-run window.
  bit     div_on = 0;
  longint last0  = -1;
  longint last1  = -1;

  always @(posedge q2[0]) begin
    if (div_on) begin
      if (last0 >= 0) check("q0_period", 32'($time - last0), 32'd20);
      last0 = $time;
    end
  end

  always @(posedge q2[1]) begin
    if (div_on) begin
      if (last1 >= 0) check("q1_period", 32'($time - last1), 32'd40);
      last1 = $time;
    end
  end

  always @(q2[1]) begin
    if (div_on) begin
      check("q1_on_q0_rise_time", 32'($time), 32'(last0));
      check("q1_on_q0_rise_lvl", {31'd0, q2[0]}, 32'd1);
    end
  end

  initial begin
    // Down count 0 -> 3 -> 2 -> 1 -> 0 twice, then enable-hold at q = 2.
    vecs[0]  = '{1'b1, 2'd3, 1'b0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0};
    vecs[2]  = '{1'b1, 2'd1, 1'b0};
    vecs[3]  = '{1'b1, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 2'd3, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 1'b1};
    vecs[8]  = '{1'b1, 2'd3, 1'b0};
    vecs[9]  = '{1'b1, 2'd2, 1'b0};
    vecs[10] = '{1'b0, 2'd2, 1'b0};
    vecs[11] = '{1'b0, 2'd2, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 2'd1, 1'b0};

    rst2 = 1'b0; en2 = 1'b1;
    rst4 = 1'b0; en4 = 1'b1;

    // Reset held for 30 time units with clk running and en high.
    #1;
    check("rst_q2_t1", {30'd0, q2}, 32'd0);
    check("rst_tc2_t1", {31'd0, tc2}, 32'd1);
    check("rst_q4_t1", {28'd0, q4}, 32'd0);
    check("rst_tc4_t1", {31'd0, tc4}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_q2_edge", {30'd0, q2}, 32'd0);
      check("rst_tc2_edge", {31'd0, tc2}, 32'd1);
      check("rst_q4_edge", {28'd0, q4}, 32'd0);
    end

    // Release reset between edges, then apply the vector table.
    @(negedge clk);
    rst2 = 1'b1;
    for (int i = 0; i < 14; i++) begin
      en2 = vecs[i].en;
      @(posedge clk); #1;
      check($sformatf("vec%0d_q", i), {30'd0, q2}, {30'd0, vecs[i].q});
      check($sformatf("vec%0d_tc", i), {31'd0, tc2}, {31'd0, vecs[i].tc});
      @(negedge clk);
    end

    // Asynchronous reset at q = 1, between clock edges.
    en2  = 1'b1;
    rst2 = 1'b0;
    #1;
    check("midrst_q", {30'd0, q2}, 32'd0);
    check("midrst_tc", {31'd0, tc2}, 32'd1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    check("after_midrst_q", {30'd0, q2}, 32'd3);
    check("after_midrst_tc", {31'd0, tc2}, 32'd0);

    // Free-run divider window.
    @(negedge clk);
    div_on = 1;
    #200;
    div_on = 0;
    check("div_q0_seen", {31'd0, (last0 >= 0)}, 32'd1);
    check("div_q1_seen", {31'd0, (last1 >= 0)}, 32'd1);

    // WIDTH = 4: 17 edges from reset -> 15 down to 0, then wrap to 15.
    @(negedge clk);
    rst4 = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] exp_q;
      exp_q = 4'((16 - k) & 15);
      @(posedge clk); #1;
      check($sformatf("w4_step%0d_q", k), {28'd0, q4}, {28'd0, exp_q});
      check($sformatf("w4_step%0d_tc", k), {31'd0, tc4}, {31'd0, (exp_q == 4'd0)});
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
